// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bundle: the ID/EX/MEM operand info the detector reads
// and the stall/flush controls it returns to the pipeline.
interface hazard_stall_ctrl_if;
    logic [2:0] ID_Rs;
    logic [2:0] ID_Rd;
    logic       ID_UsesRs;
    logic       ID_UsesRd;
    logic       ID_IsBranch;
    logic       ID_Halt;
    logic       BranchTaken;
    logic [2:0] EX_Rd;
    logic       EX_RegWrite;
    logic       EX_MemRead;
    logic [2:0] MEM_Rd;
    logic       MEM_MemRead;
    logic       PCWrite;
    logic       IFID_Write;
    logic       IFID_Flush;
    logic       IDEX_Bubble;
    logic       Halted;

    // pipeline side: supplies stage info, consumes controls
    modport master (
        output ID_Rs, ID_Rd, ID_UsesRs, ID_UsesRd, ID_IsBranch, ID_Halt, BranchTaken,
               EX_Rd, EX_RegWrite, EX_MemRead, MEM_Rd, MEM_MemRead,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Halted
    );

    // controller side
    modport slave (
        input  ID_Rs, ID_Rd, ID_UsesRs, ID_UsesRd, ID_IsBranch, ID_Halt, BranchTaken,
               EX_Rd, EX_RegWrite, EX_MemRead, MEM_Rd, MEM_MemRead,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Halted
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/flush controller. Detects load-use and branch-operand
// hazards that forwarding cannot cover, holds PC and IF/ID while injecting
// ID/EX bubbles, flushes IF/ID on taken branches and parks on halt.
// Optional macro HAZARD_PERF_EN adds saturating StallCount/FlushCount.
module hazard_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_stall_ctrl_if.slave   hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]     StallCount,
    output logic [CNT_W-1:0]     FlushCount
`endif
);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    state_t     state;
    logic [1:0] rem;
    logic [1:0] n_req;
    logic       halted_q;
    logic       match_ex;
    logic       br_ex;
    logic       br_mem;

    // CNT_W only sizes the perf counters; this empty check keeps the
    // parameter referenced in builds without them.
    if (CNT_W < 1) begin : g_cnt_w_chk
    end

    // r0 is hardwired, so it never produces a dependency
    function automatic logic hit(input logic [2:0] rd, input logic [2:0] src,
                                 input logic en);
        return en && (rd != 3'd0) && (rd == src);
    endfunction

    // Required stall length for the ID instruction, highest priority first
    always_comb begin
        match_ex = hit(hz.EX_Rd, hz.ID_Rs, hz.ID_UsesRs) |
                   hit(hz.EX_Rd, hz.ID_Rd, hz.ID_UsesRd);
        br_ex    = hit(hz.EX_Rd, hz.ID_Rs, 1'b1);
        br_mem   = hit(hz.MEM_Rd, hz.ID_Rs, 1'b1);
        n_req    = 2'd0;
        if (hz.ID_IsBranch && hz.EX_MemRead && br_ex)
            n_req = 2'd2;
        else if (hz.ID_IsBranch && hz.EX_RegWrite && br_ex)
            n_req = 2'd1;
        else if (hz.ID_IsBranch && hz.MEM_MemRead && br_mem)
            n_req = 2'd1;
        else if (!hz.ID_IsBranch && hz.EX_MemRead && match_ex)
            n_req = 2'd1;
    end

    // Pipeline controls: combinational in RUN, decoded from state otherwise
    always_comb begin
        hz.PCWrite     = 1'b1;
        hz.IFID_Write  = 1'b1;
        hz.IFID_Flush  = 1'b0;
        hz.IDEX_Bubble = 1'b0;
        unique case (state)
            RUN: begin
                if (n_req != 2'd0) begin
                    hz.PCWrite     = 1'b0;
                    hz.IFID_Write  = 1'b0;
                    hz.IDEX_Bubble = 1'b1;
                end else if (hz.ID_Halt) begin
                    // halt itself proceeds into EX, so no bubble here
                    hz.PCWrite     = 1'b0;
                    hz.IFID_Write  = 1'b0;
                end else if (hz.BranchTaken) begin
                    hz.IFID_Flush  = 1'b1;
                end
            end
            default: begin
                hz.PCWrite     = 1'b0;
                hz.IFID_Write  = 1'b0;
                hz.IDEX_Bubble = 1'b1;
            end
        endcase
        hz.Halted = halted_q;
    end

    // FSM: RUN launches stalls/halt, STALL counts down remaining cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            rem      <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (n_req != 2'd0) begin
                        rem   <= n_req - 2'd1;
                        state <= (n_req > 2'd1) ? STALL : RUN;
                    end else if (hz.ID_Halt) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                STALL: begin
                    if (rem <= 2'd1) begin
                        rem   <= 2'd0;
                        state <= RUN;
                    end else begin
                        rem <= rem - 2'd1;
                    end
                end
                HALT: state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters; parked bubbles in HALT are not stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (hz.IDEX_Bubble && state != HALT && StallCount != '1)
                StallCount <= StallCount + 1'b1;
            if (hz.IFID_Flush && FlushCount != '1)
                FlushCount <= FlushCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver pushes the expected
// control vector {PCWrite,IFID_Write,IFID_Flush,IDEX_Bubble,Halted} per
// cycle, the monitor pops and compares on the falling edge.
module tb_hazard_stall_ctrl;

    localparam logic [4:0] RUNV = 5'b11000;
    localparam logic [4:0] STL  = 5'b00010;
    localparam logic [4:0] FLU  = 5'b11100;
    localparam logic [4:0] HLT0 = 5'b00000;
    localparam logic [4:0] PARK = 5'b00011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if hz_if ();

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    hazard_stall_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
`ifdef HAZARD_PERF_EN
        ,
        .StallCount (stall_cnt),
        .FlushCount (flush_cnt)
`endif
    );

    typedef struct {
        logic [4:0] v;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [4:0] outs();
        return {hz_if.PCWrite, hz_if.IFID_Write, hz_if.IFID_Flush,
                hz_if.IDEX_Bubble, hz_if.Halted};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: compare one scoreboard entry per cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.name, {27'd0, outs()}, {27'd0, e.v});
        end
    end

    task automatic clr();
        hz_if.ID_Rs = 3'd0;       hz_if.ID_Rd = 3'd0;
        hz_if.ID_UsesRs = 1'b0;   hz_if.ID_UsesRd = 1'b0;
        hz_if.ID_IsBranch = 1'b0; hz_if.ID_Halt = 1'b0;
        hz_if.BranchTaken = 1'b0;
        hz_if.EX_Rd = 3'd0;       hz_if.EX_RegWrite = 1'b0;
        hz_if.EX_MemRead = 1'b0;
        hz_if.MEM_Rd = 3'd0;      hz_if.MEM_MemRead = 1'b0;
    endtask

    // expected vector for the cycle whose inputs are currently applied
    task automatic cyc(input string nm, input logic [4:0] v);
        exp_q.push_back('{v, nm});
        @(posedge clk);
        #1;
    endtask

    task automatic load_use();
        clr();
        hz_if.EX_MemRead = 1'b1; hz_if.EX_RegWrite = 1'b1; hz_if.EX_Rd = 3'd3;
        hz_if.ID_Rs = 3'd3;      hz_if.ID_UsesRs = 1'b1;
    endtask

    initial begin
        clr();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc("reset_idle", RUNV);
`ifdef HAZARD_PERF_EN
        chk("perf_reset_stall", {16'd0, stall_cnt}, 32'd0);
        chk("perf_reset_flush", {16'd0, flush_cnt}, 32'd0);
`endif

        // load-use: one stall, then bubble reaches EX and ID proceeds
        load_use();
        cyc("loaduse_stall", STL);
        clr(); hz_if.ID_Rs = 3'd3; hz_if.ID_UsesRs = 1'b1;
        cyc("loaduse_release", RUNV);

        // branch on load in EX: two stalls, taken branch flushes on cycle 3
        clr();
        hz_if.EX_MemRead = 1'b1; hz_if.EX_RegWrite = 1'b1; hz_if.EX_Rd = 3'd5;
        hz_if.ID_IsBranch = 1'b1; hz_if.ID_Rs = 3'd5; hz_if.ID_UsesRs = 1'b1;
        hz_if.BranchTaken = 1'b1;
        cyc("brload_stall1", STL);
        hz_if.EX_MemRead = 1'b0; hz_if.EX_RegWrite = 1'b0; hz_if.EX_Rd = 3'd0;
        hz_if.MEM_MemRead = 1'b1; hz_if.MEM_Rd = 3'd5;
        cyc("brload_stall2", STL);
        hz_if.MEM_MemRead = 1'b0; hz_if.MEM_Rd = 3'd0;
        cyc("brload_flush", FLU);
        clr();
        cyc("brload_after", RUNV);

        // branch on ALU result in EX: one stall
        clr();
        hz_if.EX_RegWrite = 1'b1; hz_if.EX_Rd = 3'd4;
        hz_if.ID_IsBranch = 1'b1; hz_if.ID_Rs = 3'd4; hz_if.ID_UsesRs = 1'b1;
        cyc("br_exalu_stall", STL);
        clr();
        cyc("br_exalu_release", RUNV);

        // branch on load in MEM: one stall
        clr();
        hz_if.MEM_MemRead = 1'b1; hz_if.MEM_Rd = 3'd6;
        hz_if.ID_IsBranch = 1'b1; hz_if.ID_Rs = 3'd6; hz_if.ID_UsesRs = 1'b1;
        cyc("br_memload_stall", STL);
        clr();
        cyc("br_memload_release", RUNV);

        // register zero never hazards
        clr();
        hz_if.EX_MemRead = 1'b1; hz_if.EX_RegWrite = 1'b1; hz_if.EX_Rd = 3'd0;
        hz_if.ID_Rs = 3'd0; hz_if.ID_UsesRs = 1'b1;
        cyc("reg_zero", RUNV);

        // Rd operand masked by UsesRd, then enabled
        clr();
        hz_if.EX_MemRead = 1'b1; hz_if.EX_Rd = 3'd2; hz_if.ID_Rd = 3'd2;
        cyc("usesrd_masked", RUNV);
        hz_if.ID_UsesRd = 1'b1;
        cyc("usesrd_stall", STL);

        // ALU result in EX for a non-branch is forwarded, no stall
        clr();
        hz_if.EX_RegWrite = 1'b1; hz_if.EX_Rd = 3'd1;
        hz_if.ID_Rs = 3'd1; hz_if.ID_UsesRs = 1'b1;
        cyc("nonbranch_alu", RUNV);

        // stall beats BranchTaken, then a plain taken branch flushes
        load_use(); hz_if.BranchTaken = 1'b1;
        cyc("stall_over_taken", STL);
        clr(); hz_if.BranchTaken = 1'b1;
        cyc("taken_flush", FLU);

        // stall beats halt: still RUN afterwards
        load_use(); hz_if.ID_Halt = 1'b1;
        cyc("stall_over_halt", STL);
        clr();
        cyc("not_halted", RUNV);

        // halt beats BranchTaken, then parked for 20 cycles
        clr(); hz_if.ID_Halt = 1'b1; hz_if.BranchTaken = 1'b1;
        cyc("halt_entry", HLT0);
        clr();
        for (int i = 0; i < 20; i++) cyc("halt_parked", PARK);

        // async reset mid-cycle leaves HALT at once
        #2 rst_n = 1'b0;
        #1;
        chk("rst_halted", {31'd0, hz_if.Halted}, 32'd0);
        chk("rst_pcwrite", {31'd0, hz_if.PCWrite}, 32'd1);
        chk("rst_bubble", {31'd0, hz_if.IDEX_Bubble}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_reset_run", RUNV);

        // three stalls and two flushes for the perf counters
        load_use();
        cyc("perf_stall1", STL);
        clr();
        cyc("perf_gap1", RUNV);
        load_use();
        cyc("perf_stall2", STL);
        clr();
        hz_if.EX_RegWrite = 1'b1; hz_if.EX_Rd = 3'd4;
        hz_if.ID_IsBranch = 1'b1; hz_if.ID_Rs = 3'd4; hz_if.ID_UsesRs = 1'b1;
        cyc("perf_stall3", STL);
        clr(); hz_if.BranchTaken = 1'b1;
        cyc("perf_flush1", FLU);
        cyc("perf_flush2", FLU);
        clr();
        cyc("perf_idle", RUNV);

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

`ifdef HAZARD_PERF_EN
        chk("perf_stall_count", {16'd0, stall_cnt}, 32'd3);
        chk("perf_flush_count", {16'd0, flush_cnt}, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Sequential stall/flush controller at the decode (ID) stage, upstream of the forwarding unit. It detects read-after-write hazards that forwarding cannot cover: load-use, and branch operands resolved in ID. For each hazard it holds PC and IF/ID and injects bubbles into ID/EX for the required number of cycles. It also flushes IF/ID on a taken branch and parks the pipeline on halt.

## Interface
Parameters:
- CNT_W, default 16: width of the performance counters (only with HAZARD_PERF_EN).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- ID_Rs  input  3  source register A of the instruction in ID.
- ID_Rd  input  3  source register B (Rd read as operand) of the instruction in ID.
- ID_UsesRs, ID_UsesRd  input  1 each  ID instruction actually reads that register.
- ID_IsBranch  input  1  ID instruction is a conditional branch; it compares ID_Rs in ID.
- ID_Halt  input  1  ID instruction is halt.
- BranchTaken  input  1  branch in ID resolved taken this cycle.
- EX_Rd  input  3  destination register in EX.
- EX_RegWrite, EX_MemRead  input  1 each  EX writes a register / EX is a load.
- MEM_Rd  input  3  destination register in MEM.
- MEM_MemRead  input  1  MEM is a load.
- PCWrite  output  1  PC may advance.
- IFID_Write  output  1  IF/ID may load.
- IFID_Flush  output  1  zero IF/ID on the next edge.
- IDEX_Bubble  output  1  load a NOP into ID/EX on the next edge.
- Halted  output  1  pipeline is parked.
- StallCount, FlushCount  output  CNT_W each  (HAZARD_PERF_EN only).

## Operation
- Register 0 never causes a hazard; a match requires the Rd to be non-zero.
- Match(X) is true when X is non-zero and equals either ID_Rs with ID_UsesRs set, or ID_Rd with ID_UsesRd set.
- Stall cycles required, N, is evaluated in RUN with priority top-down:
  - ID_IsBranch, EX_MemRead, and EX_Rd matches ID_Rs: N=2.
  - ID_IsBranch, EX_RegWrite, and EX_Rd matches ID_Rs: N=1.
  - ID_IsBranch, MEM_MemRead, and MEM_Rd matches ID_Rs: N=1.
  - non-branch, EX_MemRead, and Match(EX_Rd): N=1.
  - otherwise N=0.
- FSM states are RUN, STALL, and HALT. Stall counter `rem` is 2 bits.
- RUN with N>0:
  - Stall this cycle: PCWrite=0, IFID_Write=0, IDEX_Bubble=1.
  - rem<=N-1.
  - Next state is STALL if N-1>0, else RUN.
- RUN with N=0 and ID_Halt: PCWrite=0, IFID_Write=0, IDEX_Bubble=0 (the halt itself goes to EX). Next state HALT.
- RUN with N=0 and BranchTaken: IFID_Flush=1, PCWrite=1, IFID_Write=1.
- RUN otherwise: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- STALL: outputs match the RUN stall case. rem decrements each cycle; at rem==1, next state is RUN.
  - Inputs are not re-evaluated in STALL.
  - On return to RUN, hazard detection runs again on the same ID instruction.
- HALT: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, Halted=1. HALT is left only by reset.
- Simultaneous events:
  - A stall overrides BranchTaken (it is ignored, no flush) and ID_Halt.
  - ID_Halt overrides BranchTaken.

## Timing
- Detection and stall outputs are combinational from the inputs in RUN, so the hazard stalls the ID instruction in the same cycle it is detected. In STALL and HALT, outputs are decoded from the registered state.
- Total stall length is exactly N cycles: the first is combinational from RUN, the remaining N-1 are registered.
- Reset values: state=RUN, rem=0, Halted=0, counters=0. With all hazard inputs low, outputs are then PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- Reset asserted mid-STALL or in HALT returns to RUN immediately (asynchronously).

## Configuration
- HAZARD_PERF_EN defined:
  - StallCount increments on every cycle with IDEX_Bubble=1 outside HALT.
  - FlushCount increments on every cycle with IFID_Flush=1.
  - Both saturate at all-ones and clear on reset.
- HAZARD_PERF_EN undefined: the counter ports and their logic are absent.

## Test plan
- Load-use: EX_MemRead=1, EX_RegWrite=1, EX_Rd=3; ID_Rs=3, ID_UsesRs=1, non-branch -> exactly 1 cycle with PCWrite=0 and IDEX_Bubble=1, then RUN.
- Branch on load in EX: EX_MemRead=1, EX_Rd=5; ID_IsBranch=1, ID_Rs=5 -> 2 consecutive stall cycles, then PCWrite=1; if BranchTaken is held high throughout, IFID_Flush=1 on cycle 3 only.
- Register zero: EX_MemRead=1, EX_Rd=0, ID_Rs=0 -> no stall, PCWrite stays 1.
- ID_UsesRd=0 masking: EX load to r2, ID_Rd=2, ID_UsesRd=0, ID_UsesRs=0 -> no stall.
- Halt: ID_Halt=1 with no hazard -> Halted=1 from the next cycle and held 20 cycles. rst_n pulsed low mid-cycle -> Halted=0 immediately.
- Priority/perf: a stall and BranchTaken in the same cycle -> no flush. With HAZARD_PERF_EN, 3 stalls and 2 flushes -> StallCount=3, FlushCount=2.
